fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage program counter with branch-prediction tracking.
// It holds the PC register and a small wait/redirect FSM. It also carries each
// prediction alongside its instruction down to execute, so that a misprediction
// can be detected and the PC steered back onto the correct path.
module fetch_pc_unit #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] NextInstruction,
  input  logic                 TakingBranch,
  input  logic                 IMemReady,
  input  logic                 StallD,
  input  logic                 BranchE,
  input  logic                 ZeroE,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  output logic [WORD_SIZE-1:0] PCF,
  output logic [WORD_SIZE-1:0] PCPlus4F,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 MispredictE,
  output logic                 StallF,
  output logic [CNT_W-1:0]     BranchCount,
  output logic [CNT_W-1:0]     MispredCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t               stateReg;
  state_t               stateNext;
  logic [WORD_SIZE-1:0] pcReg;
  logic [WORD_SIZE-1:0] pcNext;
  logic                 holdPc;

  // Prediction shadow pipeline: one entry per stage, travelling with its instruction.
  logic                 predTakenD;
  logic [WORD_SIZE-1:0] predTargetD;
  logic                 predTakenE;
  logic [WORD_SIZE-1:0] predTargetE;

  logic                 pcAdvance;
  logic                 dirWrong;
  logic                 tgtWrong;
  logic                 aliasHit;
  logic [WORD_SIZE-1:0] recoveryPc;

  assign PCF      = pcReg;
  assign PCPlus4F = pcReg + WORD_SIZE'(4);

  // Memory accepted the current fetch and decode can take it, so fetch moves on.
  assign pcAdvance = IMemReady & ~StallD;

  // The execute-stage resolution is compared against the prediction that was made for it.
  // There are three failure kinds: the direction was wrong; the direction was right but
  // the target was wrong; or the predictor fired on something that is not a branch.
  assign dirWrong    = BranchE & (ZeroE != predTakenE);
  assign tgtWrong    = BranchE & ZeroE & predTakenE & (predTargetE != PCTargetE);
  assign aliasHit    = ~BranchE & predTakenE;
  assign MispredictE = dirWrong | tgtWrong | aliasHit;

  // Correct path: the resolved target if the branch is really taken, else fall-through.
  assign recoveryPc = (BranchE & ZeroE) ? PCTargetE : PCPlus4E;

  // FSM state and PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= RUN;
      pcReg    <= RESET_PC;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
    end
  end

  // Next PC, next state and flush/stall outputs. A mispredict overrides all other
  // conditions in every state. Otherwise the PC follows the predictor whenever it is allowed to advance.
  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    holdPc    = 1'b0;
    FlushD    = MispredictE;
    FlushE    = MispredictE;
    if (MispredictE) begin
      pcNext    = recoveryPc;
      stateNext = REDIRECT;
    end else begin
      if (pcAdvance) begin
        pcNext = NextInstruction;
      end else begin
        holdPc = 1'b1;
      end
      case (stateReg)
        RUN:      stateNext = IMemReady ? RUN : WAIT_MEM;
        WAIT_MEM: stateNext = IMemReady ? RUN : WAIT_MEM;
        // Lasts exactly one cycle; a still-busy memory is picked up as WAIT_MEM from RUN.
        REDIRECT: stateNext = RUN;
        default:  stateNext = RUN;
      endcase
    end
    if (stateReg == REDIRECT) begin
      FlushD = 1'b1;
    end
    StallF = holdPc;
  end

  // Shadow pipeline update. A mispredict wipes both wrong-path entries. A decode stall
  // freezes both entries. During the redirect cycle, or when no fetch is accepted, a bubble enters the decode entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      predTakenD  <= 1'b0;
      predTargetD <= '0;
      predTakenE  <= 1'b0;
      predTargetE <= '0;
    end else if (MispredictE) begin
      predTakenD  <= 1'b0;
      predTargetD <= '0;
      predTakenE  <= 1'b0;
      predTargetE <= '0;
    end else if (!StallD) begin
      predTakenE  <= predTakenD;
      predTargetE <= predTargetD;
      if ((stateReg != REDIRECT) && pcAdvance) begin
        predTakenD  <= TakingBranch;
        predTargetD <= NextInstruction;
      end else begin
        predTakenD  <= 1'b0;
        predTargetD <= '0;
      end
    end
  end

  // Statistics: index 0 counts resolved branches and index 1 counts mispredictions.
  logic [1:0] cntInc;
  assign cntInc[0] = BranchE & ~StallD;
  assign cntInc[1] = MispredictE;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    // Saturating event counter: it stops at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (cntInc[gi] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign BranchCount  = g_cnt[0].cnt;
  assign MispredCount = g_cnt[1].cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed, table-driven checks of fetch_pc_unit plus
// hand-written sequences for counter saturation and asynchronous reset.
module tb_fetch_pc_unit;

  localparam int WS = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WS-1:0] NextInstruction = '0;
  logic          TakingBranch = 1'b0;
  logic          IMemReady = 1'b1;
  logic          StallD = 1'b0;
  logic          BranchE = 1'b0;
  logic          ZeroE = 1'b0;
  logic [WS-1:0] PCTargetE = '0;
  logic [WS-1:0] PCPlus4E = '0;
  logic [WS-1:0] PCF;
  logic [WS-1:0] PCPlus4F;
  logic          FlushD;
  logic          FlushE;
  logic          MispredictE;
  logic          StallF;
  logic [CW-1:0] BranchCount;
  logic [CW-1:0] MispredCount;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit #(.WORD_SIZE(WS), .RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .NextInstruction(NextInstruction), .TakingBranch(TakingBranch),
    .IMemReady(IMemReady), .StallD(StallD),
    .BranchE(BranchE), .ZeroE(ZeroE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .PCF(PCF), .PCPlus4F(PCPlus4F),
    .FlushD(FlushD), .FlushE(FlushE), .MispredictE(MispredictE), .StallF(StallF),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ni;  logic tb; logic imr; logic sd; logic be; logic ze;
    logic [31:0] tgt; logic [31:0] p4e;
    logic [31:0] pcf; logic mis; logic fd; logic fe; logic sf;
    logic [7:0]  bc;  logic [7:0] mc;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expP4;
    //            ni            tb    imr   sd    be    ze    tgt       p4e       pcf           mis   fd    fe    sf    bc    mc
    vecs[0]  = '{32'h4,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{32'h8,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h4,        1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{32'hC,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h8,        1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{32'h10,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'hC,        1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[4]  = '{32'h40,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[5]  = '{32'h44,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h40,       1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[6]  = '{32'h48,       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40,  32'h14,  32'h44,       1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[7]  = '{32'h4C,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h48,       1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0};
    vecs[8]  = '{32'h50,       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80,  32'h4C,  32'h4C,       1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0};
    vecs[9]  = '{32'h84,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h80,       1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1};
    vecs[10] = '{32'h88,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h84,       1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1};
    vecs[11] = '{32'h8C,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h88,       1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1};
    vecs[12] = '{32'h8C,       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h24,  32'h88,       1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd1};
    vecs[13] = '{32'h28,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h24,       1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd2};
    vecs[14] = '{32'h28,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h24,       1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd2};
    vecs[15] = '{32'h2C,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h28,       1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd2};
    vecs[16] = '{32'h2C,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h28,       1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd2};
    vecs[17] = '{32'h30,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h2C,       1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd2};
    vecs[18] = '{32'h34,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h60,  32'h30,       1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd2};
    vecs[19] = '{32'h64,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h60,       1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3};
    vecs[20] = '{32'h100,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h64,       1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3};
    vecs[21] = '{32'h104,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h100,      1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3};
    vecs[22] = '{32'h108,      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h104, 32'h104,      1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd3};
    vecs[23] = '{32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h200,      1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd4};
    vecs[24] = '{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd4};
    vecs[25] = '{32'h4,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd4};

    // Reset state, checked while reset is still held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pcf", PCF, 32'h0);
    chk("reset_pcplus4", PCPlus4F, 32'h4);
    chk("reset_flush", {30'd0, FlushD, FlushE}, 32'h0);
    chk("reset_mispred", {31'd0, MispredictE}, 32'h0);
    chk("reset_counts", {16'd0, BranchCount, MispredCount}, 32'h0);
    rst = 1'b0;

    // Table-driven section: each row is one cycle, checked just before its clock edge.
    for (int i = 0; i < 26; i++) begin
      NextInstruction = vecs[i].ni;
      TakingBranch    = vecs[i].tb;
      IMemReady       = vecs[i].imr;
      StallD          = vecs[i].sd;
      BranchE         = vecs[i].be;
      ZeroE           = vecs[i].ze;
      PCTargetE       = vecs[i].tgt;
      PCPlus4E        = vecs[i].p4e;
      #1;
      expP4 = vecs[i].pcf + 32'd4;
      $display("vec %0d: PCF=%h Mis=%b FlushD=%b FlushE=%b StallF=%b Br=%0d Mp=%0d",
               i, PCF, MispredictE, FlushD, FlushE, StallF, BranchCount, MispredCount);
      chk($sformatf("v%0d_pcf", i), PCF, vecs[i].pcf);
      chk($sformatf("v%0d_pcplus4", i), PCPlus4F, expP4);
      chk($sformatf("v%0d_mispred", i), {31'd0, MispredictE}, {31'd0, vecs[i].mis});
      chk($sformatf("v%0d_flushd", i), {31'd0, FlushD}, {31'd0, vecs[i].fd});
      chk($sformatf("v%0d_flushe", i), {31'd0, FlushE}, {31'd0, vecs[i].fe});
      chk($sformatf("v%0d_stallf", i), {31'd0, StallF}, {31'd0, vecs[i].sf});
      chk($sformatf("v%0d_brcount", i), {24'd0, BranchCount}, {24'd0, vecs[i].bc});
      chk($sformatf("v%0d_mpcount", i), {24'd0, MispredCount}, {24'd0, vecs[i].mc});
      @(posedge clk);
      #1;
    end

    // Saturation: a not-predicted taken branch every cycle mispredicts every cycle.
    NextInstruction = 32'h4;
    TakingBranch    = 1'b0;
    IMemReady       = 1'b1;
    StallD          = 1'b0;
    BranchE         = 1'b1;
    ZeroE           = 1'b1;
    PCTargetE       = 32'h80;
    PCPlus4E        = 32'h0;
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      @(posedge clk);
    end
    #1;
    $display("saturate: PCF=%h Br=%0d Mp=%0d Mis=%b", PCF, BranchCount, MispredCount, MispredictE);
    chk("sat_mispred_active", {31'd0, MispredictE}, 32'h1);
    chk("sat_mpcount", {24'd0, MispredCount}, 32'hFF);
    chk("sat_brcount", {24'd0, BranchCount}, 32'hFF);
    chk("sat_pcf", PCF, 32'h80);

    // Asynchronous reset mid-cycle while the FSM is in REDIRECT.
    BranchE = 1'b0;
    ZeroE   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: PCF=%h Br=%0d Mp=%0d FlushD=%b", PCF, BranchCount, MispredCount, FlushD);
    chk("areset_pcf", PCF, 32'h0);
    chk("areset_counts", {16'd0, BranchCount, MispredCount}, 32'h0);
    chk("areset_flush", {29'd0, FlushD, FlushE, MispredictE}, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    NextInstruction = 32'h4;
    IMemReady       = 1'b1;
    #1;
    chk("post_reset_flushd", {31'd0, FlushD}, 32'h0);
    chk("post_reset_stallf", {31'd0, StallF}, 32'h0);
    @(posedge clk);
    #1;
    $display("post reset edge: PCF=%h FlushD=%b", PCF, FlushD);
    chk("post_reset_pcf", PCF, 32'h4);
    chk("post_reset_no_redirect", {31'd0, FlushD}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
